sensor_frame_packer: RTL and testbench
======================================

Name: sensor_frame_packer

Overview:
- Upstream stage of the SPI messaging controller.
- Collects per-sensor, per-axis samples arriving one at a time on a serial sample bus and assembles them into one packed frame of 2*SENSORS*BITWIDTH bits.
- Presents the frame on data/data_ready and holds it until the messaging controller pulses ack.
- Double-buffered: the next frame is captured while the current one drains over SPI.

Parameters:
SENSORS, 1, number of sensors; each sensor supplies 2 values (axis 0, axis 1)
BITWIDTH, 32, bits per sample value; 2*SENSORS*BITWIDTH must be a multiple of 16
ID_W, max(1,$clog2(2*SENSORS)), width of slot id (derived; not overridden)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
sample_valid  input  1  sample present on sample_id/sample_value
sample_id  input  ID_W  slot index k = 2*sensor + axis
sample_value  input  BITWIDTH  sample value
sample_ready  output  1  packer accepts sample this cycle
flush  input  1  discard partially captured frame
data  output  2*SENSORS*BITWIDTH  presented frame; slot k at bits [(k+1)*BITWIDTH-1 : k*BITWIDTH]
data_ready  output  1  presented frame valid
ack  input  1  single-cycle pulse from messaging controller: frame consumed
frame_count  output  16  frames transferred to output buffer, wraps
overwrite_count  output  8  samples overwriting an already-filled capture slot, saturates at 255

Behaviour:
- Reset, sampled on rising clk while rst=1: capture mask=0, capture buffer=0, data=0, data_ready=0, frame_count=0, overwrite_count=0. Reset mid-frame or mid-drain discards everything with no partial output.
- Capture side:
  - Capture buffer: NSLOT=2*SENSORS registers plus an NSLOT-bit fill mask. cap_full = all mask bits set.
  - sample_ready = !(cap_full && data_ready). Combinational from registered state only; no dependence on sample_valid.
  - Accept = sample_valid && sample_ready. On accept, write slot sample_id and set its mask bit.
  - If the mask bit was already set, the value is overwritten (latest wins) and overwrite_count increments, saturating.
  - sample_id >= NSLOT: sample is accepted and ignored, with no mask or count change.
- Transfer:
  - Occurs at a clock edge where cap_full=1 and data_ready=0.
  - data <= capture buffer, data_ready <= 1, mask <= 0, frame_count += 1.
  - A sample accepted in the same cycle lands in the fresh capture buffer: mask becomes that bit only. It is not counted as an overwrite.
  - Latency: last slot filled at edge N -> data_ready high after edge N+1, when the output is empty.
- Output side:
  - data stays stable while data_ready=1.
  - ack sampled high while data_ready=1 -> data_ready <= 0 at that edge.
  - ack while data_ready=0 is ignored.
  - No transfer may occur on the edge that consumes ack, so data_ready is low for at least one cycle between frames.
- flush:
  - Clears the mask at that edge. Buffer contents need not be cleared.
  - Has priority over a simultaneous accept, whose sample is dropped although sample_ready was high.
  - Blocks a transfer on that edge.
  - Does not affect data or data_ready.
- Backpressure: with cap_full=1 and data_ready=1, sample_ready=0 and the capture contents are frozen until ack frees the output.
- Priority per edge: rst > flush > transfer/accept; ack is handled independently on the output side.

Decomposition:
- Shared package sensor_pkg holds:
  - derived constants NSLOT, ID_W, FRAME_W = NSLOT*BITWIDTH;
  - the slot-index formula;
  - the count widths (16, 8).
- One natural sub-module: sample_capture_buffer. It owns the slot registers, the fill mask, cap_full and overwrite detection. The top level owns the output register, handshake and counters.

Test Plan (SENSORS=2, BITWIDTH=32, NSLOT=4 unless noted):
- Basic frame: samples id0..3 = 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles -> data_ready=1 one cycle after last accept; data = 0x44444444_33333333_22222222_11111111; frame_count=1.
- Backpressure: frame 1 presented with no ack, frame 2 fully sent -> sample_ready=0 from the cycle after the 4th accept. Pulse ack -> data_ready low for one cycle, then frame 2 presented; frame_count=2; sample_ready returns high.
- Overwrite: id1=0xAAAA0000, then id1=0xBBBB0000, then id0, id2, id3 -> frame slot1=0xBBBB0000; overwrite_count=1. 300 duplicate writes -> overwrite_count=255.
- Flush: fill id0 and id1, assert flush together with id2 valid -> mask=0. Then ids 0..3 fresh -> frame contains only the post-flush values; a presented frame is unaffected by flush.
- Reset mid-operation: data_ready=1 and mask=0b0011, assert rst one cycle -> data=0, data_ready=0, counts=0; the next full frame is presented normally.
- SENSORS=1: ids 0,1 = 0xDEADBEEF, 0x01234567 -> data = 0x01234567_DEADBEEF; ack then no samples -> data_ready stays 0.

Source files
------------

// File: rtl/sensor_pkg.sv
// Shared constants and helpers for the sensor frame packer: slot geometry and counter widths.
package sensor_pkg;

  localparam int COUNT_W = 16;
  localparam int OVW_W   = 8;
  localparam int OVW_MAX = 255;

  function automatic int nslot(input int sensors);
    return 2 * sensors;
  endfunction

  function automatic int id_w(input int sensors);
    return (2 * sensors > 2) ? $clog2(2 * sensors) : 1;
  endfunction

  function automatic int frame_w(input int sensors, input int bitwidth);
    return 2 * sensors * bitwidth;
  endfunction

  // Slot k holds axis `axis` of sensor `sensor`.
  function automatic int slot_index(input int sensor, input int axis);
    return 2 * sensor + axis;
  endfunction

endpackage

// File: rtl/sensor_frame_packer_if.sv
// Sample bus plus frame output of the sensor frame packer; master drives samples/flush/ack.
interface sensor_frame_packer_if
  import sensor_pkg::*;
#(
  parameter int SENSORS  = 1,
  parameter int BITWIDTH = 32
);
  localparam int NSLOT   = nslot(SENSORS);
  localparam int ID_W    = id_w(SENSORS);
  localparam int FRAME_W = frame_w(SENSORS, BITWIDTH);

  // Handshakes: a sample moves on a rising edge where sample_valid && sample_ready;
  // sample_ready never depends on sample_valid. A frame is offered while data_ready
  // is high and data stays stable until a one-cycle ack pulse is sampled with data_ready high.
  logic                sample_valid;
  logic [ID_W-1:0]     sample_id;
  logic [BITWIDTH-1:0] sample_value;
  logic                sample_ready;
  logic                flush;
  logic [FRAME_W-1:0]  data;
  logic                data_ready;
  logic                ack;
  logic [COUNT_W-1:0]  frame_count;
  logic [OVW_W-1:0]    overwrite_count;
  logic [NSLOT-1:0]    cap_mask;

  modport master (
    output sample_valid, sample_id, sample_value, flush, ack,
    input  sample_ready, data, data_ready, frame_count, overwrite_count, cap_mask
  );

  modport slave (
    input  sample_valid, sample_id, sample_value, flush, ack,
    output sample_ready, data, data_ready, frame_count, overwrite_count, cap_mask
  );

endinterface

// File: rtl/sample_capture_buffer.sv
// Capture side of the packer: slot registers, fill mask, full detection and overwrite detection.
module sample_capture_buffer #(
  parameter int NSLOT    = 2,
  parameter int BITWIDTH = 32,
  parameter int ID_W     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      accept,
  input  logic                      flush,
  input  logic                      transfer,
  input  logic [ID_W-1:0]           id,
  input  logic [BITWIDTH-1:0]       value,
  output logic [NSLOT*BITWIDTH-1:0] frame,
  output logic [NSLOT-1:0]          mask,
  output logic                      cap_full,
  output logic                      overwrite
);

  logic [BITWIDTH-1:0] slots_q [NSLOT];
  logic [BITWIDTH-1:0] slots_d [NSLOT];
  logic [NSLOT-1:0]    mask_q;
  logic [NSLOT-1:0]    mask_d;

  always_comb begin
    slots_d   = slots_q;
    mask_d    = mask_q;
    overwrite = 1'b0;
    if (flush) begin
      mask_d = '0;
    end else begin
      if (transfer) mask_d = '0;
      // A sample landing on a transfer edge starts the fresh frame, so it is never an overwrite.
      if (accept && (32'(id) < NSLOT)) begin
        slots_d[id] = value;
        mask_d[id]  = 1'b1;
        overwrite   = mask_q[id] && !transfer;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSLOT; k++) slots_q[k] <= '0;
      mask_q <= '0;
    end else begin
      slots_q <= slots_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    frame = '0;
    for (int k = 0; k < NSLOT; k++) frame[k*BITWIDTH +: BITWIDTH] = slots_q[k];
  end

  assign mask     = mask_q;
  assign cap_full = &mask_q;

endmodule

// File: rtl/sensor_frame_packer.sv
// Double-buffered sensor frame packer: captures per-slot samples, then holds a packed frame until ack.
module sensor_frame_packer
  import sensor_pkg::*;
#(
  parameter int SENSORS  = 1,
  parameter int BITWIDTH = 32
) (
  input logic                 clk,
  input logic                 rst,
  sensor_frame_packer_if.slave bus
);

  localparam int NSLOT   = nslot(SENSORS);
  localparam int ID_W    = id_w(SENSORS);
  localparam int FRAME_W = frame_w(SENSORS, BITWIDTH);

  logic [FRAME_W-1:0] data_q, data_d;
  logic               data_ready_q, data_ready_d;
  logic [COUNT_W-1:0] frame_count_q, frame_count_d;
  logic [OVW_W-1:0]   ovw_count_q, ovw_count_d;

  logic [FRAME_W-1:0] cap_frame;
  logic [NSLOT-1:0]   cap_mask;
  logic               cap_full;
  logic               overwrite;
  logic               sample_ready;
  logic               accept;
  logic               transfer;

  assign sample_ready = !(cap_full && data_ready_q);
  assign accept       = bus.sample_valid && sample_ready;
  // data_ready_q blocks the ack edge from transferring, guaranteeing a gap between frames.
  assign transfer     = cap_full && !data_ready_q && !bus.flush;

  sample_capture_buffer #(
    .NSLOT    (NSLOT),
    .BITWIDTH (BITWIDTH),
    .ID_W     (ID_W)
  ) u_capture (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept),
    .flush     (bus.flush),
    .transfer  (transfer),
    .id        (bus.sample_id),
    .value     (bus.sample_value),
    .frame     (cap_frame),
    .mask      (cap_mask),
    .cap_full  (cap_full),
    .overwrite (overwrite)
  );

  always_comb begin
    data_d        = data_q;
    data_ready_d  = data_ready_q;
    frame_count_d = frame_count_q;
    ovw_count_d   = ovw_count_q;
    if (transfer) begin
      data_d        = cap_frame;
      data_ready_d  = 1'b1;
      frame_count_d = frame_count_q + 16'd1;
    end else if (bus.ack && data_ready_q) begin
      data_ready_d = 1'b0;
    end
    if (overwrite && (ovw_count_q != OVW_W'(OVW_MAX))) ovw_count_d = ovw_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q        <= '0;
      data_ready_q  <= 1'b0;
      frame_count_q <= '0;
      ovw_count_q   <= '0;
    end else begin
      data_q        <= data_d;
      data_ready_q  <= data_ready_d;
      frame_count_q <= frame_count_d;
      ovw_count_q   <= ovw_count_d;
    end
  end

  assign bus.sample_ready    = sample_ready;
  assign bus.data            = data_q;
  assign bus.data_ready      = data_ready_q;
  assign bus.frame_count     = frame_count_q;
  assign bus.overwrite_count = ovw_count_q;
  assign bus.cap_mask        = cap_mask;

endmodule

// File: tb/tb_sensor_frame_packer.sv
// Directed bench for sensor_frame_packer: a 2-sensor instance for the main plan and a 1-sensor instance.
module tb_sensor_frame_packer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sensor_frame_packer_if #(.SENSORS(2), .BITWIDTH(32)) bus2 ();
  sensor_frame_packer_if #(.SENSORS(1), .BITWIDTH(32)) bus1 ();

  sensor_frame_packer #(.SENSORS(2), .BITWIDTH(32)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
  sensor_frame_packer #(.SENSORS(1), .BITWIDTH(32)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send2(input int id, input logic [31:0] value);
    bus2.sample_valid = 1'b1;
    bus2.sample_id    = 2'(id);
    bus2.sample_value = value;
    step();
    bus2.sample_valid = 1'b0;
  endtask

  task automatic send1(input int id, input logic [31:0] value);
    bus1.sample_valid = 1'b1;
    bus1.sample_id    = 1'(id);
    bus1.sample_value = value;
    step();
    bus1.sample_valid = 1'b0;
  endtask

  task automatic ack2();
    bus2.ack = 1'b1;
    step();
    bus2.ack = 1'b0;
  endtask

  initial begin
    bus2.sample_valid = 1'b0; bus2.sample_id = '0; bus2.sample_value = '0;
    bus2.flush = 1'b0; bus2.ack = 1'b0;
    bus1.sample_valid = 1'b0; bus1.sample_id = '0; bus1.sample_value = '0;
    bus1.flush = 1'b0; bus1.ack = 1'b0;

    // Reset state
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_data", 128'(bus2.data), 128'h0);
    check("rst_data_ready", 128'(bus2.data_ready), 128'h0);
    check("rst_frame_count", 128'(bus2.frame_count), 128'h0);
    check("rst_ovw_count", 128'(bus2.overwrite_count), 128'h0);
    check("rst_mask", 128'(bus2.cap_mask), 128'h0);
    check("rst_sample_ready", 128'(bus2.sample_ready), 128'h1);

    // Basic frame
    send2(0, 32'h11111111);
    send2(1, 32'h22222222);
    send2(2, 32'h33333333);
    send2(3, 32'h44444444);
    check("basic_not_yet_ready", 128'(bus2.data_ready), 128'h0);
    check("basic_mask_full", 128'(bus2.cap_mask), 128'hf);
    step();
    check("basic_data_ready", 128'(bus2.data_ready), 128'h1);
    check("basic_data", 128'(bus2.data), 128'h44444444_33333333_22222222_11111111);
    check("basic_frame_count", 128'(bus2.frame_count), 128'h1);
    check("basic_mask_cleared", 128'(bus2.cap_mask), 128'h0);

    // Backpressure: second frame captured while the first is held
    send2(0, 32'h55555555);
    send2(1, 32'h66666666);
    send2(2, 32'h77777777);
    send2(3, 32'h88888888);
    check("bp_sample_ready_low", 128'(bus2.sample_ready), 128'h0);
    check("bp_data_held", 128'(bus2.data), 128'h44444444_33333333_22222222_11111111);
    step();
    check("bp_still_blocked", 128'(bus2.sample_ready), 128'h0);
    check("bp_frame_count_held", 128'(bus2.frame_count), 128'h1);
    ack2();
    check("bp_gap_data_ready", 128'(bus2.data_ready), 128'h0);
    check("bp_gap_frame_count", 128'(bus2.frame_count), 128'h1);
    step();
    check("bp_frame2_ready", 128'(bus2.data_ready), 128'h1);
    check("bp_frame2_data", 128'(bus2.data), 128'h88888888_77777777_66666666_55555555);
    check("bp_frame_count2", 128'(bus2.frame_count), 128'h2);
    check("bp_sample_ready_back", 128'(bus2.sample_ready), 128'h1);
    ack2();

    // Overwrite: latest wins
    send2(1, 32'hAAAA0000);
    send2(1, 32'hBBBB0000);
    send2(0, 32'h0000000A);
    send2(2, 32'h0000000C);
    send2(3, 32'h0000000D);
    check("ovw_count_one", 128'(bus2.overwrite_count), 128'h1);
    step();
    check("ovw_frame", 128'(bus2.data), 128'h0000000D_0000000C_BBBB0000_0000000A);
    check("ovw_frame_count", 128'(bus2.frame_count), 128'h3);
    ack2();

    // Overwrite saturation: one fill plus 300 duplicates of slot 0
    send2(0, 32'h1);
    for (int i = 0; i < 300; i++) send2(0, 32'(i));
    check("ovw_saturated", 128'(bus2.overwrite_count), 128'hff);

    // Flush beats a simultaneous accept
    send2(1, 32'h2);
    check("flush_pre_mask", 128'(bus2.cap_mask), 128'h3);
    bus2.flush = 1'b1;
    bus2.sample_valid = 1'b1;
    bus2.sample_id = 2'd2;
    bus2.sample_value = 32'hDEAD0002;
    step();
    bus2.flush = 1'b0;
    bus2.sample_valid = 1'b0;
    check("flush_mask_clear", 128'(bus2.cap_mask), 128'h0);
    send2(0, 32'h00000010);
    send2(1, 32'h00000020);
    send2(2, 32'h00000030);
    send2(3, 32'h00000040);
    step();
    check("flush_frame", 128'(bus2.data), 128'h00000040_00000030_00000020_00000010);
    check("flush_frame_count", 128'(bus2.frame_count), 128'h4);

    // Flush leaves a presented frame alone
    bus2.flush = 1'b1;
    step();
    bus2.flush = 1'b0;
    check("flush_keeps_ready", 128'(bus2.data_ready), 128'h1);
    check("flush_keeps_data", 128'(bus2.data), 128'h00000040_00000030_00000020_00000010);

    // Reset mid-operation
    send2(0, 32'hCAFE0000);
    send2(1, 32'hCAFE0001);
    check("midrst_pre_mask", 128'(bus2.cap_mask), 128'h3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_data", 128'(bus2.data), 128'h0);
    check("midrst_data_ready", 128'(bus2.data_ready), 128'h0);
    check("midrst_frame_count", 128'(bus2.frame_count), 128'h0);
    check("midrst_ovw_count", 128'(bus2.overwrite_count), 128'h0);
    check("midrst_mask", 128'(bus2.cap_mask), 128'h0);
    send2(2, 32'h00000300);
    send2(0, 32'h00000100);
    send2(3, 32'h00000400);
    send2(1, 32'h00000200);
    step();
    check("midrst_frame_ready", 128'(bus2.data_ready), 128'h1);
    check("midrst_frame", 128'(bus2.data), 128'h00000400_00000300_00000200_00000100);
    check("midrst_frame_count1", 128'(bus2.frame_count), 128'h1);
    ack2();
    check("ack_clears", 128'(bus2.data_ready), 128'h0);
    ack2();
    check("ack_idle_ignored", 128'(bus2.data_ready), 128'h0);
    check("ack_idle_count", 128'(bus2.frame_count), 128'h1);

    // Single-sensor instance
    send1(0, 32'hDEADBEEF);
    send1(1, 32'h01234567);
    step();
    check("s1_data_ready", 128'(bus1.data_ready), 128'h1);
    check("s1_data", 128'(bus1.data), 128'h01234567_DEADBEEF);
    check("s1_frame_count", 128'(bus1.frame_count), 128'h1);
    bus1.ack = 1'b1;
    step();
    bus1.ack = 1'b0;
    check("s1_ack", 128'(bus1.data_ready), 128'h0);
    step();
    step();
    check("s1_stays_idle", 128'(bus1.data_ready), 128'h0);
    check("s1_count_held", 128'(bus1.frame_count), 128'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
